uv_cost_sched: RTL and testbench

Round-robin scheduler that shares one chroma sum-of-squares cost engine among `NUM_REQ` requesters (one per candidate chroma prediction mode). It grants a requester, latches its quantized levels and pulses the engine start. It then waits for engine done, returns the 32-bit cost tagged with the requester id, and tracks the minimum-cost requester across a batch. It sits between the chroma mode-evaluation front end and the shared cost engine.

---
 rtl/uv_cost_sched.sv | 138 +++++++++++++
 tb/tb_uv_cost_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uv_cost_sched.sv
// Round-robin arbiter sharing one chroma sum-of-squares cost engine among NUM_REQ requesters; tracks batch minimum.
// Latency: grant in cycle 0, engine start cycle 1, response one cycle after engine done (or at 2+TIMEOUT on timeout).
// Backpressure: requesters hold req/levels until gnt; no new grant while a job is in flight (one job at a time).
module uv_cost_sched #(
    parameter int NUM_REQ  = 4,
    parameter int LEVELS_W = 2048,
    parameter int TIMEOUT  = 15,
    parameter int ID_W     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*LEVELS_W-1:0]  req_levels,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         eng_start,
    output logic [LEVELS_W-1:0]          eng_levels,
    input  logic [31:0]                  eng_sum,
    input  logic                         eng_done,
    output logic                         rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output logic [31:0]                  rsp_cost,
    output logic                         rsp_err,
    input  logic                         batch_clr,
    output logic [ID_W-1:0]              best_id,
    output logic [31:0]                  best_cost
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cur_id;
    logic [CNT_W-1:0] wait_cnt;
    logic             sel_found;
    logic [ID_W-1:0]  sel_id;
    logic [ID_W-1:0]  rr_next;
    logic [31:0]      cmp_cost;

    // Round-robin pick: first requester at or above rr_ptr, wrapping around.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx       = '0;
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_id    = idx;
            end
        end
    end

    // Grant is only offered while idle; pointer moves just past the winner.
    always_comb begin
        gnt = '0;
        if (state == S_IDLE && sel_found) begin
            gnt[sel_id] = 1'b1;
        end
        rr_next = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
    end

    assign eng_start = (state == S_LAUNCH);
    assign rsp_valid = (state == S_RESP);

    // Job FSM: latch levels on grant, launch, wait for done or timeout, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            wait_cnt   <= '0;
            eng_levels <= '0;
            rsp_id     <= '0;
            rsp_cost   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        eng_levels <= req_levels[int'(sel_id) * LEVELS_W +: LEVELS_W];
                        cur_id     <= sel_id;
                        rr_ptr     <= rr_next;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A done arriving on the final permitted cycle still wins over the timeout.
                    if (eng_done) begin
                        rsp_id   <= cur_id;
                        rsp_cost <= eng_sum;
                        rsp_err  <= 1'b0;
                        state    <= S_RESP;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_id   <= cur_id;
                        rsp_cost <= 32'hFFFF_FFFF;
                        rsp_err  <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // A clear in the same cycle as a response wipes the old best before comparing.
    assign cmp_cost = batch_clr ? 32'hFFFF_FFFF : best_cost;

    // Batch minimum: strict less-than so ties keep the earlier winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_id   <= '0;
            best_cost <= 32'hFFFF_FFFF;
        end else if (state == S_RESP && !rsp_err && rsp_cost < cmp_cost) begin
            best_id   <= rsp_id;
            best_cost <= rsp_cost;
        end else if (batch_clr) begin
            best_id   <= '0;
            best_cost <= 32'hFFFF_FFFF;
        end
    end

endmodule

// File: tb/tb_uv_cost_sched.sv
// Directed bench for uv_cost_sched: table of jobs plus hand-written reset sequence.
// Inputs driven 1 time unit after the rising edge, outputs sampled 2 units later.
// Engine is modelled by the bench driving eng_done/eng_sum on chosen cycles.
module tb_uv_cost_sched;

    localparam int NUM_REQ  = 4;
    localparam int LEVELS_W = 2048;
    localparam int TIMEOUT  = 15;
    localparam int ID_W     = 2;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*LEVELS_W-1:0] req_levels;
    logic [NUM_REQ-1:0]          gnt;
    logic                        eng_start;
    logic [LEVELS_W-1:0]         eng_levels;
    logic [31:0]                 eng_sum;
    logic                        eng_done;
    logic                        rsp_valid;
    logic [ID_W-1:0]             rsp_id;
    logic [31:0]                 rsp_cost;
    logic                        rsp_err;
    logic                        batch_clr;
    logic [ID_W-1:0]             best_id;
    logic [31:0]                 best_cost;

    uv_cost_sched #(
        .NUM_REQ(NUM_REQ), .LEVELS_W(LEVELS_W), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_levels(req_levels), .gnt(gnt),
        .eng_start(eng_start), .eng_levels(eng_levels), .eng_sum(eng_sum),
        .eng_done(eng_done), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_cost(rsp_cost), .rsp_err(rsp_err), .batch_clr(batch_clr),
        .best_id(best_id), .best_cost(best_cost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  r;      // request pattern
        bit          keep;   // keep req high after grant
        int          dly;    // done this many cycles after start; 0 = never
        logic [31:0] sum;
        bit          clr;    // batch_clr coincident with the response
        int          id;     // expected granted id
        logic [31:0] cost;
        bit          err;
        int          bid;
        logic [31:0] bcost;
    } vec_t;

    vec_t tv[9];
    logic [LEVELS_W-1:0] lv[NUM_REQ];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_lv(input string name, input logic [LEVELS_W-1:0] act,
                          input logic [LEVELS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got low word %0h expected low word %0h at %0t",
                     name, act[31:0], exp[31:0], $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input vec_t v);
        logic [3:0] eg;
        int rsp_c;
        bit early;
        eg = 4'b0001 << v.id;
        // cycle 0: grant
        req = v.r;
        batch_clr = 1'b0;
        #2;
        chk("gnt", 64'(gnt), 64'(eg));
        tick();
        // cycle 1: engine start with latched levels
        req = v.keep ? v.r : 4'b0000;
        #2;
        chk("eng_start", 64'(eng_start), 64'd1);
        chk_lv("eng_levels", eng_levels, lv[v.id]);
        rsp_c = (v.dly > 0) ? v.dly + 2 : TIMEOUT + 2;
        early = 1'b0;
        for (int c = 2; c < rsp_c; c++) begin
            tick();
            eng_done = (v.dly > 0 && c == 1 + v.dly);
            eng_sum  = eng_done ? v.sum : 32'hDEAD_BEEF;
            #2;
            if (rsp_valid || eng_start) early = 1'b1;
        end
        chk("no_early_rsp", 64'(early), 64'd0);
        tick();
        eng_done  = 1'b0;
        eng_sum   = 32'hDEAD_BEEF;
        batch_clr = v.clr;
        #2;
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_id", 64'(rsp_id), 64'(v.id));
        chk("rsp_cost", 64'(rsp_cost), 64'(v.cost));
        chk("rsp_err", 64'(rsp_err), 64'(v.err));
        tick();
        batch_clr = 1'b0;
        #2;
        chk("rsp_pulse_end", 64'(rsp_valid), 64'd0);
        chk("best_id", 64'(best_id), 64'(v.bid));
        chk("best_cost", 64'(best_cost), 64'(v.bcost));
    endtask

    initial begin
        bit stray;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int w = 0; w < LEVELS_W / 32; w++) begin
                lv[k][w*32 +: 32] = {8'(k + 1), 8'hC3, 16'(w * 7 + k)};
            end
        end
        req_levels = {lv[3], lv[2], lv[1], lv[0]};

        //            r        keep dly sum           clr id cost          err bid bcost
        tv[0] = '{4'b1111, 1'b1, 8,  32'd100,      1'b0, 0, 32'd100,      1'b0, 0, 32'd100};
        tv[1] = '{4'b1111, 1'b1, 8,  32'd50,       1'b0, 1, 32'd50,       1'b0, 1, 32'd50};
        tv[2] = '{4'b1111, 1'b1, 8,  32'd50,       1'b0, 2, 32'd50,       1'b0, 1, 32'd50};
        tv[3] = '{4'b1111, 1'b1, 8,  32'd70,       1'b0, 3, 32'd70,       1'b0, 1, 32'd50};
        tv[4] = '{4'b1111, 1'b0, 8,  32'd900,      1'b1, 0, 32'd900,      1'b0, 0, 32'd900};
        tv[5] = '{4'b0001, 1'b0, 8,  32'd1234,     1'b1, 0, 32'd1234,     1'b0, 0, 32'd1234};
        tv[6] = '{4'b0100, 1'b0, 0,  32'd0,        1'b0, 2, 32'hFFFF_FFFF, 1'b1, 0, 32'd1234};
        tv[7] = '{4'b1000, 1'b0, 8,  32'd77,       1'b0, 3, 32'd77,       1'b0, 3, 32'd77};
        tv[8] = '{4'b0010, 1'b0, 15, 32'd5,        1'b0, 1, 32'd5,        1'b0, 1, 32'd5};

        rst_n = 1'b0;
        req = '0;
        eng_sum = 32'hDEAD_BEEF;
        eng_done = 1'b0;
        batch_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        #2;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_eng_start", 64'(eng_start), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_cost", 64'(rsp_cost), 64'd0);
        chk("rst_best_cost", 64'(best_cost), 64'hFFFF_FFFF);
        chk_lv("rst_eng_levels", eng_levels, '0);
        tick();

        for (int i = 0; i < 9; i++) begin
            run_job(tv[i]);
        end

        // Reset in the middle of WAIT, then a stray done must be ignored.
        req = 4'b0100;
        #2;
        chk("mr_gnt", 64'(gnt), 64'b0100);
        tick();
        req = 4'b0000;
        for (int c = 2; c <= 5; c++) tick();
        rst_n = 1'b0;
        #2;
        chk("mr_eng_start", 64'(eng_start), 64'd0);
        chk("mr_rsp_id", 64'(rsp_id), 64'd0);
        chk("mr_rsp_cost", 64'(rsp_cost), 64'd0);
        chk("mr_rsp_err", 64'(rsp_err), 64'd0);
        chk("mr_best_id", 64'(best_id), 64'd0);
        chk("mr_best_cost", 64'(best_cost), 64'hFFFF_FFFF);
        chk_lv("mr_eng_levels", eng_levels, '0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        eng_done = 1'b1;
        eng_sum = 32'd99;
        stray = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (rsp_valid || eng_start || gnt != 4'b0000) stray = 1'b1;
            tick();
            eng_done = 1'b0;
            eng_sum = 32'hDEAD_BEEF;
        end
        chk("mr_no_rsp", 64'(stray), 64'd0);
        chk("mr_best_after", 64'(best_cost), 64'hFFFF_FFFF);
        // rr_ptr must be back at zero
        req = 4'b1111;
        #2;
        chk("mr_rr_ptr", 64'(gnt), 64'b0001);
        req = 4'b0000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
